compactador_imediato: RTL and testbench
=======================================

# compactador_imediato

Narrows 32-bit signed values into the processor's 16-bit and 21-bit immediate fields. Sits on the instruction-generation path (loader/assembler side) as the inverse of the immediate sign-extender: whenever no overflow is flagged, extending its output gives back the original value. Uses valid/ready handshakes on both sides with a 2-entry skid buffer, so it can run at full throughput under backpressure.

## Interface
- `CNT_W`, default 8: width of the saturating overflow counter.
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block can accept a beat.
- `valor`  in  32  two's-complement value to narrow.
- `ctrl`  in  1  format select: 1 = 16-bit field, 0 = 21-bit field.
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  consumer accepts the beat.
- `out16`  out  16  narrowed field; meaningful when `out_ctrl`=1.
- `out21`  out  21  narrowed field; meaningful when `out_ctrl`=0.
- `out_ctrl`  out  1  `ctrl` carried along with the result.
- `overflow`  out  1  `valor` does not fit the selected field.
- `erro_count`  out  CNT_W  number of overflowed beats delivered; saturates at its maximum.

## Operation
- Accept a beat when `in_valid && in_ready`. Deliver a beat when `out_valid && out_ready`.
- Fit rule, 16-bit field: `valor[31:15]` is all-0 or all-1.
- Fit rule, 21-bit field: `valor[31:20]` is all-0 or all-1.
- Default field value is truncation: `out16 = valor[15:0]`, `out21 = valor[20:0]`. Both fields are always computed.
- The field not selected is still driven with its truncated value; the consumer ignores it.
- Storage is a 2-entry buffer holding {fields, out_ctrl, overflow}.
- Entry order is strict FIFO. Entry 0 drives the outputs.
- `in_ready` = 1 when fewer than 2 entries are held. The state is registered, so there is no combinational path from `out_ready`.
- Simultaneous accept and deliver:
  - With 1 entry held, occupancy stays 1 and the new beat replaces the delivered one.
  - With 2 entries held, accept is impossible (`in_ready`=0).
- `erro_count` increments on each delivered beat that has `overflow`=1; it holds at 2^CNT_W−1.
- Reset:
  - `out_valid`=0, `in_ready`=1, `erro_count`=0, all held entries discarded.
  - `out16`, `out21`, `out_ctrl` and `overflow` read 0.
  - Reset asserted mid-transfer drops buffered beats; no beat is delivered in the reset cycle.

## Timing
- Latency is 1 cycle: a beat accepted at edge N gives `out_valid`=1 after edge N (when the buffer was empty).
- Throughput is 1 beat per cycle while `out_ready`=1.
- `in_ready` falls the cycle after the buffer becomes full and rises the cycle after a deliver frees an entry.
- `out_valid` and the output fields stay stable while `out_valid && !out_ready`.

## Configuration
- Macro: `IMM_SATURATE_EN`.
- Defined: on overflow the field is clamped instead of truncated, and `overflow` is still asserted.
  - 16-bit: 0x7FFF for positive values, 0x8000 for negative.
  - 21-bit: 0x0FFFFF for positive values, 0x100000 for negative.
- Not defined: truncation as described in Operation. No clamp logic is present.

## Structure
- Shared package holds:
  - width constants `IMM16_W`=16, `IMM21_W`=21, `WORD_W`=32;
  - `ctrl` encodings `FMT_16`=1, `FMT_21`=0;
  - saturation bounds;
  - the packed buffer-entry typedef.
- Sub-module `buffer_skid`: generic 2-entry valid/ready buffer, parameterised on data width. The top level contains the fit check, clamp/truncate and counter.

## Test plan
- Round-trip: `valor`=0xFFFF8000 with `ctrl`=1 → `out16`=0x8000, `overflow`=0. `valor`=0x000FFFFF with `ctrl`=0 → `out21`=0x0FFFFF, `overflow`=0. Sign-extending each output returns `valor`.
- Overflow: `valor`=0x00008000 with `ctrl`=1 → `overflow`=1 and `erro_count` 0→1. Without the macro `out16`=0x8000; with `IMM_SATURATE_EN` `out16`=0x7FFF.
- Backpressure: hold `out_ready`=0 and offer 3 beats A, B, C → A and B accepted and `in_ready`=0 from the next cycle. Release `out_ready` → A, B, C delivered in order with no loss or duplication.
- Streaming: `out_ready`=1 and 100 back-to-back beats → 100 deliveries, each 1 cycle after acceptance.
- Reset mid-operation: 2 entries held, assert `reset` for 1 cycle → `out_valid`=0, `in_ready`=1, `erro_count`=0 and the held beats never appear.
- Counter saturation: `CNT_W`=2, deliver 5 overflowed beats → `erro_count` reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/compactador_imediato_pkg.sv
// compactador_imediato_pkg
// Shared definitions for the immediate compactor: word and field widths,
// format-select encodings, saturation bounds and the buffered entry layout.
// Optional feature macro used by the top level: IMM_SATURATE_EN.
package compactador_imediato_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned IMM16_W = 16;
  localparam int unsigned IMM21_W = 21;

  // ctrl encodings
  localparam logic FMT_16 = 1'b1;
  localparam logic FMT_21 = 1'b0;

  // Clamp bounds, used only when saturation is built in
  localparam logic [IMM16_W-1:0] SAT16_POS = 16'h7FFF;
  localparam logic [IMM16_W-1:0] SAT16_NEG = 16'h8000;
  localparam logic [IMM21_W-1:0] SAT21_POS = 21'h0FFFFF;
  localparam logic [IMM21_W-1:0] SAT21_NEG = 21'h100000;

  // One buffered result beat
  typedef struct packed {
    logic [IMM16_W-1:0] out16;
    logic [IMM21_W-1:0] out21;
    logic               out_ctrl;
    logic               overflow;
  } entrada_t;

  localparam int unsigned ENTRADA_W = $bits(entrada_t);

  // Clamp value for the 16-bit field given the sign of the source word
  function automatic logic [IMM16_W-1:0] limite16(input logic negativo);
    return negativo ? SAT16_NEG : SAT16_POS;
  endfunction

  // Clamp value for the 21-bit field given the sign of the source word
  function automatic logic [IMM21_W-1:0] limite21(input logic negativo);
    return negativo ? SAT21_NEG : SAT21_POS;
  endfunction

endpackage

// File: rtl/compactador_imediato_if.sv
// compactador_imediato_if
// Handshake bundle of the immediate compactor.
//   input side : in_valid, in_ready, valor[31:0], ctrl
//   output side: out_valid, out_ready, out16[15:0], out21[20:0], out_ctrl, overflow
// Modports: slave = the compactor, master = the producer/consumer around it.
interface compactador_imediato_if;
  import compactador_imediato_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [WORD_W-1:0]  valor;
  logic               ctrl;
  logic               out_valid;
  logic               out_ready;
  logic [IMM16_W-1:0] out16;
  logic [IMM21_W-1:0] out21;
  logic               out_ctrl;
  logic               overflow;

  modport slave (
    input  in_valid, valor, ctrl, out_ready,
    output in_ready, out_valid, out16, out21, out_ctrl, overflow
  );

  modport master (
    output in_valid, valor, ctrl, out_ready,
    input  in_ready, out_valid, out16, out21, out_ctrl, overflow
  );

endinterface

// File: rtl/compactador_imediato_buffer_skid.sv
// buffer_skid
// Generic 2-entry FIFO with valid/ready on both sides. Entry 0 (slot0)
// drives out_data. in_ready and out_valid are flops derived from the next
// occupancy, so there is no combinational path from out_ready to in_ready.
// Ports:
//   clock, reset         : clock, synchronous active-high reset
//   in_valid/in_ready    : upstream handshake, in_data payload
//   out_valid/out_ready  : downstream handshake, out_data payload
module buffer_skid #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  typedef enum logic [1:0] {
    VAZIO = 2'd0,
    UM    = 2'd1,
    CHEIO = 2'd2
  } estado_t;

  estado_t           estado;
  logic [DATA_W-1:0] slot0;
  logic [DATA_W-1:0] slot1;

  // Occupancy state machine; handshake flags track the state one-to-one
  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= VAZIO;
      slot0     <= '0;
      slot1     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (estado)
        VAZIO: begin
          if (in_valid) begin
            slot0     <= in_data;
            estado    <= UM;
            out_valid <= 1'b1;
          end
        end
        UM: begin
          if (in_valid && out_ready) begin
            // delivered beat is replaced by the incoming one
            slot0 <= in_data;
          end else if (in_valid) begin
            slot1    <= in_data;
            estado   <= CHEIO;
            in_ready <= 1'b0;
          end else if (out_ready) begin
            estado    <= VAZIO;
            out_valid <= 1'b0;
          end
        end
        CHEIO: begin
          if (out_ready) begin
            slot0    <= slot1;
            estado   <= UM;
            in_ready <= 1'b1;
          end
        end
        default: begin
          estado    <= VAZIO;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = slot0;

endmodule

// File: rtl/compactador_imediato.sv
// compactador_imediato
// Narrows a 32-bit signed word into the 16-bit (ctrl=1) or 21-bit (ctrl=0)
// immediate field, flags values that do not fit and counts delivered
// overflowed beats (saturating). Results pass through a 2-entry buffer.
// Ports:
//   clock, reset : clock, synchronous active-high reset
//   bus          : compactador_imediato_if.slave handshake bundle
//   erro_count   : overflowed beats delivered, holds at 2^CNT_W-1
// Build option: IMM_SATURATE_EN clamps the selected field on overflow
// instead of truncating it.
module compactador_imediato
  import compactador_imediato_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  compactador_imediato_if.slave  bus,
  output logic [CNT_W-1:0]       erro_count
);

  entrada_t novo;
  entrada_t atual;
  logic     cabe16;
  logic     cabe21;
  logic     out_valid_i;
  logic     entregue;

  // Fit check: bits above the field's sign bit must replicate it
  assign cabe16 = (&bus.valor[WORD_W-1:IMM16_W-1]) | ~(|bus.valor[WORD_W-1:IMM16_W-1]);
  assign cabe21 = (&bus.valor[WORD_W-1:IMM21_W-1]) | ~(|bus.valor[WORD_W-1:IMM21_W-1]);

  // Build the entry: both fields truncated, selected one clamped if enabled
  always_comb begin
    novo.out16    = bus.valor[IMM16_W-1:0];
    novo.out21    = bus.valor[IMM21_W-1:0];
    novo.out_ctrl = bus.ctrl;
    novo.overflow = (bus.ctrl == FMT_16) ? ~cabe16 : ~cabe21;
`ifdef IMM_SATURATE_EN
    if (novo.overflow) begin
      if (bus.ctrl == FMT_16) begin
        novo.out16 = limite16(bus.valor[WORD_W-1]);
      end else begin
        novo.out21 = limite21(bus.valor[WORD_W-1]);
      end
    end
`endif
  end

  buffer_skid #(
    .DATA_W (ENTRADA_W)
  ) u_buffer (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (novo),
    .out_valid (out_valid_i),
    .out_ready (bus.out_ready),
    .out_data  (atual)
  );

  assign bus.out_valid = out_valid_i;
  assign bus.out16     = atual.out16;
  assign bus.out21     = atual.out21;
  assign bus.out_ctrl  = atual.out_ctrl;
  assign bus.overflow  = atual.overflow;

  assign entregue = out_valid_i & bus.out_ready;

  // Saturating count of delivered overflowed beats
  always_ff @(posedge clock) begin
    if (reset) begin
      erro_count <= '0;
    end else if (entregue && atual.overflow && (erro_count != {CNT_W{1'b1}})) begin
      erro_count <= erro_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_compactador_imediato.sv
// tb_compactador_imediato
// Directed bench: reset state, round-trip and overflow vectors, backpressure,
// streaming, reset mid-operation and counter saturation (second instance, CNT_W=2).
module tb_compactador_imediato;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] erro_a;
  logic [1:0] erro_b;

  int n_tests = 0;
  int n_fail  = 0;
  int n_deliv = 0;
  int exp_err = 0;
  int snap;

  compactador_imediato_if bus_a ();
  compactador_imediato_if bus_b ();

  compactador_imediato #(.CNT_W(8)) dut_a (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus_a),
    .erro_count (erro_a)
  );

  compactador_imediato #(.CNT_W(2)) dut_b (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus_b),
    .erro_count (erro_b)
  );

  always #5 clock = ~clock;

  // Deliveries seen on instance A
  always @(posedge clock) begin
    if (!reset && bus_a.out_valid && bus_a.out_ready) n_deliv++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated beat through A with out_ready=1
  task automatic beat(input string tag, input logic [31:0] v, input logic c,
                      input logic [15:0] e16, input logic [20:0] e21, input logic eov);
    logic [31:0] ext;
    bus_a.in_valid = 1'b1;
    bus_a.valor    = v;
    bus_a.ctrl     = c;
    tick();
    bus_a.in_valid = 1'b0;
    chk({tag, ".valid"},    32'(bus_a.out_valid), 32'd1);
    chk({tag, ".out16"},    32'(bus_a.out16),     32'(e16));
    chk({tag, ".out21"},    32'(bus_a.out21),     32'(e21));
    chk({tag, ".out_ctrl"}, 32'(bus_a.out_ctrl),  32'(c));
    chk({tag, ".overflow"}, 32'(bus_a.overflow),  32'(eov));
    if (!eov) begin
      ext = c ? {{16{bus_a.out16[15]}}, bus_a.out16} : {{11{bus_a.out21[20]}}, bus_a.out21};
      chk({tag, ".signext"}, ext, v);
    end
    if (eov && exp_err < 255) exp_err++;
    tick();
    chk({tag, ".drained"}, 32'(bus_a.out_valid), 32'd0);
    chk({tag, ".erro"},    32'(erro_a),          32'(exp_err));
  endtask

  initial begin
    int exp_sat [5];
    exp_sat = '{1, 2, 3, 3, 3};

    reset = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.valor = '0; bus_a.ctrl = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.valor = '0; bus_b.ctrl = 1'b0; bus_b.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst.out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("rst.in_ready",  32'(bus_a.in_ready),  32'd1);
    chk("rst.erro",      32'(erro_a),          32'd0);
    chk("rst.out16",     32'(bus_a.out16),     32'd0);
    chk("rst.out21",     32'(bus_a.out21),     32'd0);
    chk("rst.out_ctrl",  32'(bus_a.out_ctrl),  32'd0);
    chk("rst.overflow",  32'(bus_a.overflow),  32'd0);

    // Round-trip, boundary and overflow vectors
    bus_a.out_ready = 1'b1;
    beat("rt16",  32'hFFFF8000, 1'b1, 16'h8000, 21'h1F8000, 1'b0);
    beat("rt21",  32'h000FFFFF, 1'b0, 16'hFFFF, 21'h0FFFFF, 1'b0);
`ifdef IMM_SATURATE_EN
    beat("ov16p", 32'h00008000, 1'b1, 16'h7FFF, 21'h008000, 1'b1);
`else
    beat("ov16p", 32'h00008000, 1'b1, 16'h8000, 21'h008000, 1'b1);
`endif
    beat("max16", 32'h00007FFF, 1'b1, 16'h7FFF, 21'h007FFF, 1'b0);
`ifdef IMM_SATURATE_EN
    beat("ov16n", 32'hFFFF7FFF, 1'b1, 16'h8000, 21'h1F7FFF, 1'b1);
    beat("ov21p", 32'h00100000, 1'b0, 16'h0000, 21'h0FFFFF, 1'b1);
`else
    beat("ov16n", 32'hFFFF7FFF, 1'b1, 16'h7FFF, 21'h1F7FFF, 1'b1);
    beat("ov21p", 32'h00100000, 1'b0, 16'h0000, 21'h100000, 1'b1);
`endif
    beat("min21", 32'hFFF00000, 1'b0, 16'h0000, 21'h100000, 1'b0);
`ifdef IMM_SATURATE_EN
    beat("ov21n", 32'h80000000, 1'b0, 16'h0000, 21'h100000, 1'b1);
`else
    beat("ov21n", 32'h80000000, 1'b0, 16'h0000, 21'h000000, 1'b1);
`endif

    // Backpressure: A, B accepted, C held off until space frees
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.ctrl      = 1'b1;
    bus_a.valor     = 32'h0000_0011;
    tick();
    chk("bp.A.in_ready", 32'(bus_a.in_ready), 32'd1);
    chk("bp.A.out16",    32'(bus_a.out16),    32'h11);
    bus_a.valor = 32'h0000_0022;
    tick();
    chk("bp.full.in_ready",  32'(bus_a.in_ready),  32'd0);
    chk("bp.full.out_valid", 32'(bus_a.out_valid), 32'd1);
    chk("bp.full.out16",     32'(bus_a.out16),     32'h11);
    bus_a.valor = 32'h0000_0033;
    tick();
    chk("bp.stall.in_ready", 32'(bus_a.in_ready), 32'd0);
    chk("bp.stall.out16",    32'(bus_a.out16),    32'h11);
    bus_a.out_ready = 1'b1;
    tick();
    chk("bp.B.out16",    32'(bus_a.out16),    32'h22);
    chk("bp.B.in_ready", 32'(bus_a.in_ready), 32'd1);
    tick();
    chk("bp.C.out16",     32'(bus_a.out16),     32'h33);
    chk("bp.C.out_valid", 32'(bus_a.out_valid), 32'd1);
    bus_a.in_valid = 1'b0;
    tick();
    chk("bp.empty", 32'(bus_a.out_valid), 32'd0);

    // Streaming: 100 back-to-back beats, each visible one cycle after accept
    snap = n_deliv;
    bus_a.in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus_a.valor = 32'(i + 256);
      tick();
      chk("stream.valid",    32'(bus_a.out_valid), 32'd1);
      chk("stream.out16",    32'(bus_a.out16),     32'(i + 256));
      chk("stream.in_ready", 32'(bus_a.in_ready),  32'd1);
    end
    bus_a.in_valid = 1'b0;
    tick();
    chk("stream.end",   32'(bus_a.out_valid), 32'd0);
    chk("stream.count", 32'(n_deliv - snap),  32'd100);

    // Reset with two overflowed entries held
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.ctrl      = 1'b1;
    bus_a.valor     = 32'h0000_8000;
    tick();
    tick();
    chk("rmid.full", 32'(bus_a.in_ready), 32'd0);
    snap = n_deliv;
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_err = 0;
    chk("rmid.out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("rmid.in_ready",  32'(bus_a.in_ready),  32'd1);
    chk("rmid.erro",      32'(erro_a),          32'd0);
    chk("rmid.out16",     32'(bus_a.out16),     32'd0);
    chk("rmid.overflow",  32'(bus_a.overflow),  32'd0);
    tick();
    tick();
    chk("rmid.no_deliv", 32'(n_deliv - snap), 32'd0);
    chk("rmid.erro2",    32'(erro_a),         32'd0);

    // Counter saturation on the CNT_W=2 instance
    bus_b.out_ready = 1'b1;
    bus_b.ctrl      = 1'b1;
    bus_b.valor     = 32'h0000_8000;
    for (int k = 0; k < 5; k++) begin
      bus_b.in_valid = 1'b1;
      tick();
      bus_b.in_valid = 1'b0;
      tick();
      chk("sat.erro", 32'(erro_b), 32'(exp_sat[k]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
